// File: rtl/and_chain_pkg.sv
// Shared types and constants for the and-chain capture block: sample layout,
// the three legal and-chain patterns and the default FIFO depth.
package and_chain_pkg;

    typedef struct packed {
        logic o;
        logic o1_hi;
        logic o1_lo;
    } sample_t;

    localparam logic [2:0] LEGAL_ZERO = 3'b000;
    localparam logic [2:0] LEGAL_LAST = 3'b001;
    localparam logic [2:0] LEGAL_ONES = 3'b111;

    localparam int DEPTH_DEFAULT = 4;

    // A consistent chain has O equal to its upstream tap, and the top tap can
    // never be high while the one below it is low.
    function automatic logic is_legal(input sample_t s);
        logic [2:0] bits;
        bits = s;
        return (bits == LEGAL_ZERO) || (bits == LEGAL_LAST) || (bits == LEGAL_ONES);
    endfunction

endpackage

// File: rtl/and_chain_capture_if.sv
// Sample/handshake bundle between the and-chain and its capture FIFO.
// With AND_CHAIN_CAPTURE_PARITY_EN defined the bundle also carries out_par.
interface and_chain_capture_if #(
    parameter int CNT_W = 8
);
    logic             O;
    logic [1:0]       O1;
    logic             in_valid;
    logic [2:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] drop_cnt;
    logic             chk_err;
`ifdef AND_CHAIN_CAPTURE_PARITY_EN
    logic             out_par;

    modport master (
        output O, O1, in_valid, out_ready,
        input  out_data, out_valid, drop_cnt, chk_err, out_par
    );
    modport slave (
        input  O, O1, in_valid, out_ready,
        output out_data, out_valid, drop_cnt, chk_err, out_par
    );
`else
    modport master (
        output O, O1, in_valid, out_ready,
        input  out_data, out_valid, drop_cnt, chk_err
    );
    modport slave (
        input  O, O1, in_valid, out_ready,
        output out_data, out_valid, drop_cnt, chk_err
    );
`endif
endinterface

// File: rtl/and_chain_fifo_mem.sv
// First-word-fall-through storage for the capture FIFO: entry array, wrapping
// pointers and occupancy. The caller guarantees no push when full without a pop.
module and_chain_fifo_mem
    import and_chain_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        // DEPTH is a power of two, so plain increment wraps modulo DEPTH.
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/and_chain_capture.sv
// Captures and-chain samples into a FWFT FIFO, counts samples lost while full
// and flags inconsistent chains. AND_CHAIN_CAPTURE_PARITY_EN adds per-entry parity.
module and_chain_capture
    import and_chain_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    and_chain_capture_if.slave   bus
);
`ifdef AND_CHAIN_CAPTURE_PARITY_EN
    localparam int ENTRY_W = 4;
`else
    localparam int ENTRY_W = 3;
`endif

    sample_t            in_s;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;
    logic               empty, full;
    logic               push, pop, drop;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               chk_err_q, chk_err_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_s = {bus.O, bus.O1};
    assign pop  = !empty && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;

`ifdef AND_CHAIN_CAPTURE_PARITY_EN
    assign wdata       = {^in_s, in_s};
    assign bus.out_par = empty ? 1'b0 : rdata[3];
`else
    assign wdata = in_s;
`endif

    and_chain_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_mem (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        chk_err_d  = chk_err_q;
        if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
        if (bus.in_valid && !is_legal(in_s)) begin
            chk_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            drop_cnt_q <= '0;
            chk_err_q  <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            chk_err_q  <= chk_err_d;
        end
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 3'b000 : rdata[2:0];
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.chk_err   = chk_err_q;

endmodule

// File: tb/tb_and_chain_capture.sv
// Directed bench for and_chain_capture: DEPTH=4 with an 8-bit and a 2-bit
// drop counter instance fed the same stimulus.
module tb_and_chain_capture;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    and_chain_capture_if #(.CNT_W(8)) bus  ();
    and_chain_capture_if #(.CNT_W(2)) bus2 ();

    assign bus2.O         = bus.O;
    assign bus2.O1        = bus.O1;
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.out_ready = bus.out_ready;

    and_chain_capture #(.DEPTH(4), .CNT_W(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    and_chain_capture #(.DEPTH(4), .CNT_W(2)) dut2 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus2.slave)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0] pat6 [6]  = '{3'b111, 3'b001, 3'b000, 3'b111, 3'b001, 3'b000};
    logic [2:0] seq  [14] = '{3'b111, 3'b001, 3'b000, 3'b111, 3'b001, 3'b001, 3'b000,
                              3'b111, 3'b111, 3'b000, 3'b001, 3'b000, 3'b111, 3'b001};

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s);
        bus.in_valid = v;
        {bus.O, bus.O1} = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 3'b000);
        bus.out_ready = 1'b0;
        RESET = 1'b1;
        step();
        step();
        check_vec("rst_valid", bus.out_valid, 0);
        check_vec("rst_data", bus.out_data, 0);
        check_vec("rst_drop", bus.drop_cnt, 0);
        check_vec("rst_chk", bus.chk_err, 0);
        check_vec("rst_drop2", bus2.drop_cnt, 0);
        RESET = 1'b0;

        // Streaming with downstream always ready: one-edge latency.
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b111); step();
        check_vec("st_valid0", bus.out_valid, 1);
        check_vec("st_data0", bus.out_data, 3'b111);
        drive(1'b1, 3'b001); step();
        check_vec("st_data1", bus.out_data, 3'b001);
        drive(1'b1, 3'b000); step();
        check_vec("st_valid2", bus.out_valid, 1);
        check_vec("st_data2", bus.out_data, 3'b000);
        drive(1'b0, 3'b000); step();
        check_vec("st_empty_valid", bus.out_valid, 0);
        check_vec("st_empty_data", bus.out_data, 0);
        check_vec("st_drop", bus.drop_cnt, 0);
        check_vec("st_chk", bus.chk_err, 0);

        // Overfill with downstream stalled: 4 kept, 2 dropped.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, pat6[i]);
            step();
        end
        check_vec("of_drop", bus.drop_cnt, 2);
        check_vec("of_drop2", bus2.drop_cnt, 2);
        drive(1'b0, 3'b000);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_vec("of_drain_valid", bus.out_valid, 1);
            check_vec("of_drain_data", bus.out_data, pat6[i]);
            step();
        end
        check_vec("of_drained", bus.out_valid, 0);

        // Full FIFO with simultaneous push and pop for 10 cycles.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq[i]);
            step();
        end
        bus.out_ready = 1'b1;
        for (int k = 4; k < 14; k++) begin
            drive(1'b1, seq[k]);
            step();
            check_vec("pp_valid", bus.out_valid, 1);
            check_vec("pp_data", bus.out_data, seq[k-3]);
        end
        check_vec("pp_drop", bus.drop_cnt, 2);
        drive(1'b0, 3'b000);
        for (int j = 11; j < 14; j++) begin
            step();
            check_vec("pp_tail", bus.out_data, seq[j]);
        end
        step();
        check_vec("pp_empty", bus.out_valid, 0);

        // Saturation of the 2-bit counter, held head while stalled.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq[i]);
            step();
        end
        drive(1'b1, 3'b001); step();
        check_vec("sat_drop2_first", bus2.drop_cnt, 3);
        check_vec("sat_drop_first", bus.drop_cnt, 3);
        for (int i = 0; i < 4; i++) step();
        check_vec("sat_drop2", bus2.drop_cnt, 3);
        check_vec("sat_drop", bus.drop_cnt, 7);
        check_vec("sat_hold", bus.out_data, seq[0]);
        check_vec("sat_chk", bus.chk_err, 0);

        // Reset while full overrides a same-cycle push and pop.
        bus.out_ready = 1'b1;
        RESET = 1'b1; step();
        check_vec("mr_valid", bus.out_valid, 0);
        check_vec("mr_data", bus.out_data, 0);
        check_vec("mr_drop", bus.drop_cnt, 0);
        check_vec("mr_drop2", bus2.drop_cnt, 0);
        RESET = 1'b0;

        // Reset with three entries stored, then a fresh push.
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b111); step();
        drive(1'b1, 3'b000); step();
        drive(1'b1, 3'b111); step();
        check_vec("r3_head", bus.out_data, 3'b111);
        RESET = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b001); step();
        check_vec("r3_valid", bus.out_valid, 0);
        RESET = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b001); step();
        check_vec("r3_new_valid", bus.out_valid, 1);
        check_vec("r3_new_data", bus.out_data, 3'b001);
`ifdef AND_CHAIN_CAPTURE_PARITY_EN
        check_vec("r3_par", bus.out_par, 1);
`endif
        drive(1'b0, 3'b000);
        bus.out_ready = 1'b1;
        step();
        check_vec("r3_popped", bus.out_valid, 0);

        // Inconsistent chain sets a sticky error.
        drive(1'b1, 3'b101); step();
        check_vec("ce_set", bus.chk_err, 1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 3'b000);
            step();
        end
        check_vec("ce_sticky", bus.chk_err, 1);
        drive(1'b0, 3'b000); step();
        RESET = 1'b1; step();
        check_vec("ce_clear", bus.chk_err, 0);
        RESET = 1'b0;

        // A dropped inconsistent sample still raises the error.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b000);
            step();
        end
        check_vec("cd_pre", bus.chk_err, 0);
        drive(1'b1, 3'b110); step();
        check_vec("cd_chk", bus.chk_err, 1);
        check_vec("cd_drop", bus.drop_cnt, 1);
        drive(1'b0, 3'b000);
        RESET = 1'b1; step();
        check_vec("cd_clear", bus.chk_err, 0);
        RESET = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/and_chain_capture.md
AND_CHAIN_CAPTURE -- requirements
Module: and_chain_capture

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; SHALL be a power of two, 2..16.
REQ-002 Parameter CNT_W, default 8, width of the drop counter.
REQ-003 CLK  input  1  the single clock; all state SHALL update on the rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 O  input  1  upstream and-chain final output (and2_3 result).
REQ-006 O1  input  2  upstream tap pair {and2_3, and2_2}.
REQ-007 in_valid  input  1  upstream sample qualifier; there is no upstream ready, so the block never stalls upstream.
REQ-008 out_data  output  3  head sample {O, O1[1], O1[0]}.
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_ready  input  1  downstream accepts the head.
REQ-011 drop_cnt  output  CNT_W  number of samples lost while full, saturating.
REQ-012 chk_err  output  1  sticky upstream consistency error.

Function
REQ-013 Push: in_valid=1 and (count<DEPTH or pop in the same cycle) SHALL write {O,O1} at the write pointer.
REQ-014 Pop: out_valid=1 and out_ready=1 SHALL advance the read pointer.
REQ-015 FWFT: a sample pushed into an empty FIFO at edge N SHALL appear on out_data with out_valid=1 after edge N; no extra latency.
REQ-016 Simultaneous push and pop while full SHALL be accepted, leaving count at DEPTH; the same applies at any other occupancy (count unchanged).
REQ-017 in_valid=1 while full and no pop SHALL drop the sample and increment drop_cnt; drop_cnt SHALL saturate at 2^CNT_W-1.
REQ-018 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-019 out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-020 out_data is don't-care when out_valid=0, but SHALL be driven 3'b000 in that case.
REQ-021 Check: for every in_valid sample, O!=O1[1] or O1==2'b10 SHALL set chk_err on the following edge. This applies to dropped samples too.
REQ-022 chk_err SHALL remain set until RESET.
REQ-023 Pop with out_valid=0 SHALL be ignored.

Reset
REQ-024 RESET=1 SHALL clear the pointers, set count=0, out_valid=0, out_data=0, drop_cnt=0 and chk_err=0 at the next edge, overriding any push or pop in that cycle.
REQ-025 Reset mid-operation SHALL discard all stored entries.
REQ-026 Storage array contents need no reset.

Configuration
REQ-027 Macro AND_CHAIN_CAPTURE_PARITY_EN, when defined, SHALL add:
- output out_par (1), the even parity of out_data, stored per entry;
- a 4th storage bit per entry.
REQ-028 Without AND_CHAIN_CAPTURE_PARITY_EN, out_par and the extra storage bit SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Shared package and_chain_pkg SHALL hold:
- the sample typedef (3-bit packed struct o, o1_hi, o1_lo);
- the legal-pattern constants 3'b000, 3'b001, 3'b111;
- the DEPTH default.
REQ-030 Storage plus pointers SHALL be a sub-module and_chain_fifo_mem. Check, drop counter and handshake logic SHALL stay in the top.

Verification
REQ-031 Reset, then push 3'b111, 3'b001, 3'b000 with out_ready=1 -> same order on out_data, one per cycle after a 1-edge latency; drop_cnt=0, chk_err=0.
REQ-032 out_ready=0, push 6 samples, DEPTH=4 -> count 4, drop_cnt=2; then out_ready=1 -> the first 4 samples are returned in order.
REQ-033 Full FIFO, in_valid=1 and out_ready=1 for 10 cycles -> drop_cnt unchanged, out_valid stays 1, output order preserved.
REQ-034 Push O=1, O1=2'b01 -> chk_err=1 after the next edge and stays 1 through 20 clean samples; RESET -> 0.
REQ-035 CNT_W=2, 5 drops -> drop_cnt saturates at 3.
REQ-036 Assert RESET with 3 entries stored -> out_valid=0 after the edge; a subsequent push is returned correctly. With AND_CHAIN_CAPTURE_PARITY_EN defined, out_par=1 for 3'b001.
